// File: rtl/user_gpio_in_cond.sv
// user_gpio_in_cond
//   Conditions asynchronous FPGA input pins before the Zynq PS reads them.
//   Per bit: 2-FF synchronizer -> debounce filter -> rise/fall edge pulses.
//   Optional sticky interrupt status with a combined, maskable IRQ line,
//   compiled in when the macro GPIO_IN_IRQ_EN is defined.
// Ports
//   clk              system clock (PS FCLK domain)
//   rst_n            synchronous reset, active-low
//   gpio_input       raw asynchronous pin levels
//   zynq_gpio_input  debounced level (registered)
//   zynq_gpio_rise   1-cycle pulse on debounced 0->1
//   zynq_gpio_fall   1-cycle pulse on debounced 1->0
//   zynq_irq_mask    1 = bit may raise zynq_irq
//   zynq_irq_clear   write-1-to-clear per status bit
//   zynq_irq_status  sticky per-bit event flags (0 when IRQ logic absent)
//   zynq_irq         OR of enabled status bits, registered (0 when absent)
module user_gpio_in_cond #(
   parameter int unsigned WIDTH           = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gpio_input,
   output logic [WIDTH-1:0] zynq_gpio_input,
   output logic [WIDTH-1:0] zynq_gpio_rise,
   output logic [WIDTH-1:0] zynq_gpio_fall,
   input  logic [WIDTH-1:0] zynq_irq_mask,
   input  logic [WIDTH-1:0] zynq_irq_clear,
   output logic [WIDTH-1:0] zynq_irq_status,
   output logic             zynq_irq
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1_q,   s1_d;
   logic [WIDTH-1:0] s2_q,   s2_d;
   logic [WIDTH-1:0] lvl_q,  lvl_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // Synchronizer, per-bit debounce counters and edge detection.
   // The counter tracks consecutive cycles where s2 disagrees with the
   // accepted level; any agreeing cycle restarts it, so it stops at CNT_LAST.
   always_comb begin
      s1_d  = gpio_input;
      s2_d  = s1_q;
      lvl_d = lvl_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != lvl_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               lvl_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      rise_d = lvl_d & ~lvl_q;
      fall_d = ~lvl_d & lvl_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q   <= '0;
         s2_q   <= '0;
         lvl_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         lvl_q  <= lvl_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign zynq_gpio_input = lvl_q;
   assign zynq_gpio_rise  = rise_q;
   assign zynq_gpio_fall  = fall_q;

`ifdef GPIO_IN_IRQ_EN
   logic [WIDTH-1:0] status_q, status_d;
   logic             irq_q,    irq_d;

   // Sticky status: a new edge event wins over a simultaneous clear.
   always_comb begin
      status_d = (status_q & ~zynq_irq_clear) | rise_q | fall_q;
      irq_d    = |(status_q & zynq_irq_mask);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         status_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         status_q <= status_d;
         irq_q    <= irq_d;
      end
   end

   assign zynq_irq_status = status_q;
   assign zynq_irq        = irq_q;
`else
   // Interrupt inputs have no function in this build.
   logic unused_irq_inputs;
   assign unused_irq_inputs = ^{zynq_irq_mask, zynq_irq_clear};
   assign zynq_irq_status   = '0;
   assign zynq_irq          = 1'b0;
`endif

endmodule

// File: tb/tb_user_gpio_in_cond.sv
// Bench for user_gpio_in_cond (WIDTH=2, DEBOUNCE_CYCLES=4): a directed
// vector table with hand-derived expectations, followed by random pin
// activity, both continuously checked against a sliding-window model.
module tb_user_gpio_in_cond;

   localparam int unsigned W = 2;
   localparam int unsigned D = 4;
`ifdef GPIO_IN_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] gpio_input, irq_mask, irq_clear;
   logic [W-1:0] dut_lvl, dut_rise, dut_fall, dut_status;
   logic         dut_irq;

   user_gpio_in_cond #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .gpio_input      (gpio_input),
      .zynq_gpio_input (dut_lvl),
      .zynq_gpio_rise  (dut_rise),
      .zynq_gpio_fall  (dut_fall),
      .zynq_irq_mask   (irq_mask),
      .zynq_irq_clear  (irq_clear),
      .zynq_irq_status (dut_status),
      .zynq_irq        (dut_irq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic         rst_n;
      logic [W-1:0] pins, mask, clr;
      logic [W-1:0] lvl, rise, fall, status;
      logic         irq;
   } vec_t;
   vec_t tbl[$];

   // Model: pin samples taken at each edge, newest first. A bit's level
   // flips when the D samples seen by the filter (2 edges of sync delay)
   // all hold the opposite value.
   logic [W-1:0] hist [D+2];
   logic [W-1:0] m_lvl, m_rise, m_fall, m_status;
   logic         m_irq;

   task automatic model_edge(input logic r, input logic [W-1:0] p, m, c);
      logic [W-1:0] nl, ns;
      logic         ni, flip;
      if (!r) begin
         for (int k = 0; k < int'(D) + 2; k++) hist[k] = '0;
         m_lvl = '0; m_rise = '0; m_fall = '0; m_status = '0; m_irq = 1'b0;
      end else begin
         for (int k = int'(D) + 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = p;
         nl = m_lvl;
         for (int i = 0; i < int'(W); i++) begin
            flip = 1'b1;
            for (int k = 2; k <= int'(D) + 1; k++)
               if (hist[k][i] == m_lvl[i]) flip = 1'b0;
            if (flip) nl[i] = ~m_lvl[i];
         end
         ns = IRQ_EN ? ((m_status & ~c) | m_rise | m_fall) : '0;
         ni = IRQ_EN ? |(m_status & m) : 1'b0;
         m_rise   = nl & ~m_lvl;
         m_fall   = ~nl & m_lvl;
         m_lvl    = nl;
         m_status = ns;
         m_irq    = ni;
      end
   endtask

   task automatic chk(input string nm, input int cyc, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @step %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
   task automatic step(input int cyc, input logic r, input logic [W-1:0] p, m, c);
      rst_n      = r;
      gpio_input = p;
      irq_mask   = m;
      irq_clear  = c;
      @(posedge clk);
      model_edge(r, p, m, c);
      #1;
      chk("model_lvl",    cyc, 8'(dut_lvl),    8'(m_lvl));
      chk("model_rise",   cyc, 8'(dut_rise),   8'(m_rise));
      chk("model_fall",   cyc, 8'(dut_fall),   8'(m_fall));
      chk("model_status", cyc, 8'(dut_status), 8'(m_status));
      chk("model_irq",    cyc, 8'(dut_irq),    8'(m_irq));
      chk("rise_and_fall", cyc, 8'(dut_rise & dut_fall), 8'd0);
   endtask

   task automatic add(input int n, input logic r, input logic [W-1:0] p, m, c,
                      input logic [W-1:0] l, ri, f, s, input logic i);
      vec_t v;
      v.rst_n = r; v.pins = p; v.mask = m; v.clr = c;
      v.lvl = l; v.rise = ri; v.fall = f; v.status = s; v.irq = i;
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endtask

   initial begin
      logic [W-1:0] p, m, c;
      int           run [W];
      logic [W-1:0] exp_s;
      logic         exp_i;

      rst_n = 1'b0; gpio_input = '0; irq_mask = '0; irq_clear = '0;
      for (int k = 0; k < int'(D) + 2; k++) hist[k] = '0;
      m_lvl = '0; m_rise = '0; m_fall = '0; m_status = '0; m_irq = 1'b0;

      //   n  rst pins mask clr  lvl rise fall stat irq
      add(3, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); // 0-2 reset
      add(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); // 3 first after reset
      add(6, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); // 4-9
      add(5, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); // 10-14 pin0 high
      add(1, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0); // 15 accepted
      add(1, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0); // 16
      add(3, 1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0); // 17-19 pin1 short
      add(4, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0); // 20-23 rejected
      add(5, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0); // 24-28 pin0 low
      add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 0); // 29 fall
      add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0); // 30
      add(1, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0); // 31 clear
      add(2, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); // 32-33
      add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); // 34 bounce
      add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); // 35
      add(5, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); // 36-40
      add(1, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0); // 41 accepted
      add(1, 1, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 0); // 42 set beats clear
      add(1, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0); // 43
      add(1, 1, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 0); // 44 clear
      add(1, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0); // 45
      add(5, 1, 2'b11, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0); // 46-50 pin1 up, mask 01
      add(1, 1, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 0); // 51
      add(3, 1, 2'b11, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 0); // 52-54 masked
      add(5, 1, 2'b10, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 0); // 55-59 pin0 down
      add(1, 1, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 0); // 60
      add(1, 1, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 0); // 61
      add(2, 1, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 1); // 62-63 irq
      add(1, 1, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 1); // 64 clear bit0
      add(2, 1, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 0); // 65-66 irq drops
      add(5, 1, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 0); // 67-71 both bits
      add(1, 1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 0); // 72
      add(1, 1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 0); // 73
      add(1, 1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 1); // 74
      add(3, 1, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 1); // 75-77 pending
      add(1, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); // 78 reset
      add(5, 1, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); // 79-83 restart
      add(1, 1, 2'b10, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 0); // 84
      add(2, 1, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 0); // 85-86

      foreach (tbl[n]) begin
         step(n, tbl[n].rst_n, tbl[n].pins, tbl[n].mask, tbl[n].clr);
         exp_s = IRQ_EN ? tbl[n].status : '0;
         exp_i = IRQ_EN ? tbl[n].irq : 1'b0;
         chk("vec_lvl",    n, 8'(dut_lvl),    8'(tbl[n].lvl));
         chk("vec_rise",   n, 8'(dut_rise),   8'(tbl[n].rise));
         chk("vec_fall",   n, 8'(dut_fall),   8'(tbl[n].fall));
         chk("vec_status", n, 8'(dut_status), 8'(exp_s));
         chk("vec_irq",    n, 8'(dut_irq),    8'(exp_i));
      end

      // Random runs per bit: short runs exercise glitch rejection, long ones acceptance.
      p = gpio_input;
      m = 2'b01;
      for (int i = 0; i < int'(W); i++) run[i] = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < int'(W); i++) begin
            if (run[i] == 0) begin
               p[i]   = 1'($urandom_range(0, 1));
               run[i] = int'($urandom_range(1, 8));
            end
            run[i]--;
         end
         if ($urandom_range(0, 49) == 0) m = W'($urandom);
         c = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
         step(1000 + n, ($urandom_range(0, 399) != 0), p, m, c);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
